// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between the CPU (port 0) and the IO/loader (port 1).
// Each grant runs exactly one RAM access; every output is a register.
module mem_port_arbiter #(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 16,
  parameter bit          FIXED_PRI = 1'b0
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,

  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,

  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_d,
  input  logic [DW-1:0] ram_q
);

  typedef enum logic {StIdle, StAccess} state_e;

  state_e state_q;
  logic   last_q;  // port granted most recently
  logic   cur_q;   // port owning the current access

  logic elig0, elig1, start, pick1;

  // The port in its own access cycle is not eligible; its req is ignored.
  always_comb begin
    elig0 = req0 & ~((state_q == StAccess) & ~cur_q);
    elig1 = req1 & ~((state_q == StAccess) & cur_q);
    start = elig0 | elig1;
    if (elig0 && elig1) begin
      pick1 = FIXED_PRI ? 1'b1 : ~last_q;
    end else begin
      pick1 = elig1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      cur_q    <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_d    <= '0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;

      // Closing edge of a read access: capture the RAM output for the owner.
      if (state_q == StAccess && !ram_we) begin
        if (cur_q) begin
          rdata1  <= ram_q;
          rvalid1 <= 1'b1;
        end else begin
          rdata0  <= ram_q;
          rvalid0 <= 1'b1;
        end
      end

      if (start) begin
        state_q  <= StAccess;
        cur_q    <= pick1;
        last_q   <= pick1;
        gnt0     <= ~pick1;
        gnt1     <= pick1;
        ram_we   <= pick1 ? we1 : we0;
        ram_addr <= pick1 ? addr1 : addr0;
        ram_d    <= pick1 ? wdata1 : wdata0;
      end else begin
        state_q <= StIdle;
        gnt0    <= 1'b0;
        gnt1    <= 1'b0;
        ram_we  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of the arbitration rules and RAM contents.
module tb_mem_port_arbiter;

  logic clk, rst;

  logic        req0, we0, req1, we1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, ram_we;
  logic [15:0] rdata0, rdata1, ram_d, ram_q;
  logic [7:0]  ram_addr;

  logic        f_req0, f_we0, f_req1, f_we1;
  logic [7:0]  f_addr0, f_addr1;
  logic [15:0] f_wdata0, f_wdata1;
  logic        f_gnt0, f_gnt1, f_rvalid0, f_rvalid1, f_ram_we;
  logic [15:0] f_rdata0, f_rdata1, f_ram_d, f_ram_q;
  logic [7:0]  f_ram_addr;

  logic [15:0] mem_a [256];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [15:0] pl_data;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(.AW(8), .DW(16), .FIXED_PRI(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_d(ram_d), .ram_q(ram_q)
  );

  mem_port_arbiter #(.AW(8), .DW(16), .FIXED_PRI(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .req0(f_req0), .we0(f_we0), .addr0(f_addr0), .wdata0(f_wdata0),
    .gnt0(f_gnt0), .rvalid0(f_rvalid0), .rdata0(f_rdata0),
    .req1(f_req1), .we1(f_we1), .addr1(f_addr1), .wdata1(f_wdata1),
    .gnt1(f_gnt1), .rvalid1(f_rvalid1), .rdata1(f_rdata1),
    .ram_we(f_ram_we), .ram_addr(f_ram_addr), .ram_d(f_ram_d), .ram_q(f_ram_q)
  );

  // RAM model for the round-robin instance; the fixed-priority one reads a pattern.
  assign ram_q   = mem_a[ram_addr];
  assign f_ram_q = {8'h00, f_ram_addr};

  always @(posedge clk) begin
    if (ram_we) mem_a[ram_addr] <= ram_d;
    else if (pl_en) mem_a[pl_addr] <= pl_data;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({gnt0, gnt1, rvalid0, rvalid1, ram_we, ram_addr, ram_d, rdata0, rdata1} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b %b %b %b %b %h %h %h %h want all 0", gnt0, gnt1,
               rvalid0, rvalid1, ram_we, ram_addr, ram_d, rdata0, rdata1);
    end
    #10;
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({gnt0, gnt1, ram_we, f_gnt0, f_gnt1} !== '0) begin
      n_err++;
      $display("FAIL reset_idle: got %b%b%b%b%b want 00000", gnt0, gnt1, ram_we, f_gnt0, f_gnt1);
    end
  endtask

  task automatic test_cpu_read();
    preload(8'h10, 16'hBEEF);
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    tick();
    n_cmp++;
    if ({gnt0, gnt1, ram_we} !== 3'b100 || ram_addr !== 8'h10) begin
      n_err++;
      $display("FAIL cpu_read_grant: got gnt %b%b we %b addr %h want 10 0 10", gnt0, gnt1,
               ram_we, ram_addr);
    end
    req0 = 1'b0;
    tick();
    n_cmp++;
    if (rvalid0 !== 1'b1 || rdata0 !== 16'hBEEF || rvalid1 !== 1'b0 || gnt0 !== 1'b0) begin
      n_err++;
      $display("FAIL cpu_read_resp: got rv %b%b rdata0 %h gnt0 %b want 10 beef 0", rvalid0,
               rvalid1, rdata0, gnt0);
    end
    tick();
    n_cmp++;
    if (rvalid0 !== 1'b0 || rdata0 !== 16'hBEEF) begin
      n_err++;
      $display("FAIL cpu_read_pulse: got rv0 %b rdata0 %h want 0 beef", rvalid0, rdata0);
    end
  endtask

  task automatic test_io_write_cpu_read();
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h20; wdata1 = 16'h1234;
    tick();
    n_cmp++;
    if ({gnt1, gnt0, ram_we} !== 3'b101 || ram_addr !== 8'h20 || ram_d !== 16'h1234) begin
      n_err++;
      $display("FAIL io_write_cmd: got gnt %b%b we %b addr %h d %h want 10 1 20 1234", gnt1,
               gnt0, ram_we, ram_addr, ram_d);
    end
    req1 = 1'b0;
    tick();
    n_cmp++;
    if (ram_we !== 1'b0 || rvalid1 !== 1'b0 || mem_a[8'h20] !== 16'h1234) begin
      n_err++;
      $display("FAIL io_write_done: got we %b rv1 %b mem %h want 0 0 1234", ram_we, rvalid1,
               mem_a[8'h20]);
    end
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h20;
    tick();
    req0 = 1'b0;
    tick();
    n_cmp++;
    if (rvalid0 !== 1'b1 || rdata0 !== 16'h1234) begin
      n_err++;
      $display("FAIL io_then_cpu_read: got rv0 %b rdata0 %h want 1 1234", rvalid0, rdata0);
    end
    tick();
  endtask

  task automatic test_contention_rr();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (gnt0 !== (i % 2 == 0) || gnt1 !== (i % 2 == 1)) begin
        n_err++;
        $display("FAIL rr_order[%0d]: got gnt %b%b want %b%b", i, gnt0, gnt1, i % 2 == 0,
                 i % 2 == 1);
      end
      n_cmp++;
      if (rvalid0 !== (i >= 1 && i % 2 == 1) || rvalid1 !== (i >= 2 && i % 2 == 0)) begin
        n_err++;
        $display("FAIL rr_rvalid[%0d]: got %b%b", i, rvalid0, rvalid1);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_fixed_pri();
    f_req0 = 1'b1; f_we0 = 1'b0; f_addr0 = 8'h31;
    f_req1 = 1'b1; f_we1 = 1'b0; f_addr1 = 8'h42;
    tick();
    n_cmp++;
    if ({f_gnt1, f_gnt0} !== 2'b10 || f_ram_addr !== 8'h42) begin
      n_err++;
      $display("FAIL fp_first: got gnt %b%b addr %h want 10 42", f_gnt1, f_gnt0, f_ram_addr);
    end
    f_req1 = 1'b0;
    tick();
    n_cmp++;
    if ({f_gnt1, f_gnt0} !== 2'b01 || f_rvalid1 !== 1'b1 || f_rdata1 !== 16'h0042) begin
      n_err++;
      $display("FAIL fp_second: got gnt %b%b rv1 %b rd1 %h want 01 1 0042", f_gnt1, f_gnt0,
               f_rvalid1, f_rdata1);
    end
    f_req0 = 1'b0;
    tick();
    f_req0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (f_gnt0 !== (i % 2 == 0) || f_gnt1 !== 1'b0) begin
        n_err++;
        $display("FAIL fp_single[%0d]: got gnt %b%b want 0%b", i, f_gnt1, f_gnt0, i % 2 == 0);
      end
    end
    f_req0 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_withdrawal();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h03;
    tick();
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h07; wdata1 = 16'hFFFF;
    #2;
    req1 = 1'b0;
    tick();
    n_cmp++;
    if ({gnt0, gnt1, ram_we} !== 3'b000 || rvalid0 !== 1'b1) begin
      n_err++;
      $display("FAIL withdraw_edge: got gnt %b%b we %b rv0 %b want 00 0 1", gnt0, gnt1, ram_we,
               rvalid0);
    end
    tick();
    n_cmp++;
    if ({gnt0, gnt1, ram_we, rvalid1} !== 4'b0000) begin
      n_err++;
      $display("FAIL withdraw_idle: got %b%b%b%b want 0000", gnt0, gnt1, ram_we, rvalid1);
    end
  endtask

  task automatic test_random();
    logic [15:0] ref_mem [16];
    logic        s_req [2];
    logic        s_we [2];
    logic [7:0]  s_addr [2];
    logic [15:0] s_wd [2];
    logic [15:0] exp_rd [2];
    logic [7:0]  exp_addr;
    logic [15:0] exp_d, pend_data;
    logic        pend, exp_we;
    int          busy, last, win, pend_port;
    bit          e0, e1, fresh;
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 16'($urandom);
      preload(8'(i), ref_mem[i]);
    end
    rst = 1'b0;
    #1;
    rst = 1'b1;
    busy = -1; last = 1; pend = 1'b0; pend_port = 0; pend_data = '0;
    exp_rd[0] = '0; exp_rd[1] = '0; exp_addr = '0; exp_d = '0;
    for (int c = 0; c < 600; c++) begin
      s_req[0] = req0; s_we[0] = we0; s_addr[0] = addr0; s_wd[0] = wdata0;
      s_req[1] = req1; s_we[1] = we1; s_addr[1] = addr1; s_wd[1] = wdata1;
      tick();
      // Response from the access that closed at this edge.
      if (pend) exp_rd[pend_port] = pend_data;
      n_cmp++;
      if (rvalid0 !== (pend && pend_port == 0) || rvalid1 !== (pend && pend_port == 1) ||
          rdata0 !== exp_rd[0] || rdata1 !== exp_rd[1]) begin
        n_err++;
        $display("FAIL rand_resp c%0d: got rv %b%b rd %h %h want rv %b%b rd %h %h", c, rvalid0,
                 rvalid1, rdata0, rdata1, pend && pend_port == 0, pend && pend_port == 1,
                 exp_rd[0], exp_rd[1]);
      end
      // Arbitration decided at this edge.
      e0 = s_req[0] && busy != 0;
      e1 = s_req[1] && busy != 1;
      if (e0 && e1) win = 1 - last;
      else if (e0) win = 0;
      else if (e1) win = 1;
      else win = -1;
      busy = win;
      pend = 1'b0;
      exp_we = 1'b0;
      if (win >= 0) begin
        last = win;
        exp_we = s_we[win];
        exp_addr = s_addr[win];
        exp_d = s_wd[win];
        pend_port = win;
        if (s_we[win]) ref_mem[s_addr[win][3:0]] = s_wd[win];
        else begin
          pend = 1'b1;
          pend_data = ref_mem[s_addr[win][3:0]];
        end
      end
      n_cmp++;
      if (gnt0 !== (win == 0) || gnt1 !== (win == 1) || ram_we !== exp_we ||
          ram_addr !== exp_addr || ram_d !== exp_d) begin
        n_err++;
        $display("FAIL rand_cmd c%0d: got gnt %b%b we %b a %h d %h want gnt %b%b we %b a %h d %h",
                 c, gnt0, gnt1, ram_we, ram_addr, ram_d, win == 0, win == 1, exp_we, exp_addr,
                 exp_d);
      end
      // Requesters hold their command until granted, then may issue another.
      for (int p = 0; p < 2; p++) begin
        fresh = 1'b0;
        if (s_req[p] && win == p) begin
          fresh = $urandom_range(1, 0) == 1;
          if (!fresh) begin
            if (p == 0) req0 = 1'b0;
            else req1 = 1'b0;
          end
        end else if (!s_req[p]) begin
          fresh = $urandom_range(2, 0) == 0;
        end
        if (fresh) begin
          if (p == 0) begin
            req0 = 1'b1; we0 = 1'($urandom_range(1, 0));
            addr0 = 8'($urandom_range(15, 0)); wdata0 = 16'($urandom);
          end else begin
            req1 = 1'b1; we1 = 1'($urandom_range(1, 0));
            addr1 = 8'($urandom_range(15, 0)); wdata1 = 16'($urandom);
          end
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_async();
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h05; wdata0 = 16'hAAAA;
    tick();
    n_cmp++;
    if (gnt0 !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'h05) begin
      n_err++;
      $display("FAIL rst_pre_write: got gnt0 %b we %b addr %h want 1 1 05", gnt0, ram_we,
               ram_addr);
    end
    #2;
    rst = 1'b0;
    req0 = 1'b0;
    #1;
    n_cmp++;
    if (ram_we !== 1'b0 || gnt0 !== 1'b0 || ram_addr !== 8'h00) begin
      n_err++;
      $display("FAIL rst_async: got we %b gnt0 %b addr %h want 0 0 00", ram_we, gnt0, ram_addr);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({gnt0, gnt1, rvalid0, rvalid1, ram_we, ram_addr, ram_d, rdata0, rdata1} !== '0) begin
      n_err++;
      $display("FAIL rst_release: got %b %b %b %b %b %h %h %h %h want all 0", gnt0, gnt1,
               rvalid0, rvalid1, ram_we, ram_addr, ram_d, rdata0, rdata1);
    end
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h08;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h09;
    tick();
    n_cmp++;
    if ({gnt0, gnt1} !== 2'b10 || ram_addr !== 8'h08) begin
      n_err++;
      $display("FAIL rst_first_tie: got gnt %b%b addr %h want 10 08", gnt0, gnt1, ram_addr);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    f_req0 = 1'b0; f_we0 = 1'b0; f_addr0 = '0; f_wdata0 = '0;
    f_req1 = 1'b0; f_we1 = 1'b0; f_addr1 = '0; f_wdata1 = '0;
    f_wdata0 = 16'h0; f_wdata1 = 16'h0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    test_reset();
    test_cpu_read();
    test_io_write_cpu_read();
    test_contention_rr();
    test_fixed_pri();
    test_withdrawal();
    test_random();
    test_reset_async();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 256x16 RAM between two requesters.
  - Port 0: CPU datapath (MAR/MDR path).
  - Port 1: IO/loader port (program load and debug, which drives the MemRW_IO/MemAddr_IO/MemD_IO side).
- Arbitrates with a registered FSM and executes exactly one RAM access per grant.
- Returns read data through a registered response.
- Sits between datapath/IO logic and the ram instance inside proj1.

Parameters:
- AW, 8, RAM address width.
- DW, 16, RAM data width.
- FIXED_PRI, 0: 0 = round-robin; 1 = port 1 (IO) wins every contended arbitration.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0  in  1  CPU access request.
- we0  in  1  CPU write enable (1 = write, 0 = read).
- addr0  in  AW  CPU address.
- wdata0  in  DW  CPU write data.
- gnt0  out  1  CPU access executing this cycle.
- rvalid0  out  1  CPU read data valid (1-cycle pulse).
- rdata0  out  DW  CPU read data.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for IO.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_d  out  DW  RAM write data.
- ram_q  in  DW  RAM read data; combinational from ram_addr.

Behaviour:
- Reset: rst=0 forces the following immediately, regardless of clk, including mid-access:
  - state=IDLE
  - gnt0/gnt1/rvalid0/rvalid1/ram_we=0
  - ram_addr=0, ram_d=0, rdata0=0, rdata1=0
  - last-grant pointer=1, so port 0 wins the first tie.
- All outputs are registered. No combinational path exists from any req to gnt or to the ram_* outputs.
- FSM has two states: IDLE and ACCESS.
- IDLE, on the rising edge:
  - No eligible req: stay in IDLE, ram_we=0.
  - Otherwise: pick a winner, latch its we/addr/wdata into ram_we/ram_addr/ram_d, set gnt[winner]=1, go to ACCESS.
- ACCESS is exactly one cycle:
  - gnt[winner]=1 and the RAM sees the latched command.
  - A write commits at the end of the cycle.
  - At the closing edge, for a read: rdata[winner]<=ram_q and rvalid[winner]<=1 for one cycle. A write produces no rvalid.
  - ram_we drops to 0 at that edge unless a new write is granted (see back-to-back).
- Back-to-back:
  - At the ACCESS closing edge, only the non-winner is eligible.
  - If the non-winner's req=1, the arbiter goes directly to a new ACCESS for it, with zero idle cycles.
  - Otherwise it returns to IDLE, and ram_addr/ram_d hold their last values.
- Handshake:
  - The requester holds req/we/addr/wdata stable from assertion until it samples gnt=1.
  - req during its own gnt cycle is ignored and is not a new request.
  - A requester wanting another access keeps req high; it is re-eligible from IDLE.
  - A single continuously-requesting port is therefore granted every other cycle.
- Arbitration:
  - Only one requester eligible: it wins.
  - Both eligible with FIXED_PRI=0: the port not granted last wins, and the pointer updates on every grant.
  - Both eligible with FIXED_PRI=1: port 1 wins.
- Read latency: 2 edges from req sampled to rvalid (req at edge N, gnt in cycle N..N+1, rvalid/rdata after edge N+1).
- rdataX holds its value until the next read response on that port.
- gnt0 and gnt1 are never both 1. rvalid0 and rvalid1 are never both 1.
- Deasserting req before the grant: if it is dropped before the sampling edge, no access occurs. Once gnt is asserted, the access completes even if req drops.
- Reset during ACCESS with a write: ram_we goes to 0 asynchronously. Whether the RAM committed the write is undefined.

Test Plan:
- Reset: drive rst=0 mid-ACCESS of a write to 0x05 -> ram_we=0 at once without waiting for an edge; after release, all outputs are 0, state is IDLE, and the first contended grant goes to port 0.
- CPU read: RAM[0x10]=0xBEEF; req0=1, we0=0, addr0=0x10 at edge 0 -> gnt0=1 in cycle 1 with ram_addr=0x10; rvalid0=1 and rdata0=0xBEEF in cycle 2; rvalid1 stays 0.
- IO write then CPU read: port 1 writes 0x1234 to 0x20 -> ram_we=1 for exactly one cycle with ram_addr=0x20 and ram_d=0x1234, no rvalid1; a subsequent port 0 read of 0x20 -> rdata0=0x1234.
- Contention, FIXED_PRI=0: req0 and req1 both held high from reset release for 8 edges -> grant order 0,1,0,1,… every cycle with no idle gaps; gnt0 and gnt1 are never high together.
- Contention, FIXED_PRI=1: both requesting from IDLE -> port 1 granted first, port 0 granted on the next cycle. Single requester req0 held continuously -> gnt0 pattern 1,0,1,0.
- Request withdrawal: raise req1 and drop it before the next edge while port 0 is in ACCESS -> no port 1 grant, no ram_we pulse, FSM returns to IDLE.
